// File: rtl/alu_control_seq_if.sv
// Request/response bundle between the main decoder and the ALU control sequencer.
// The master side issues ALUOp/Funct requests; the slave side returns the decoded
// control code together with handshake and stall information.
interface alu_control_seq_if #(
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic [2:0]        ALUOp;
  logic [5:0]        Funct;
  logic              flush;
  logic              ready;
  logic              out_valid;
  logic [CTRL_W-1:0] alucontrol;
  logic              jr;
  logic              illegal;
  logic              stall;

  modport master (
    output in_valid, ALUOp, Funct, flush,
    input  ready, out_valid, alucontrol, jr, illegal, stall
  );

  modport slave (
    input  in_valid, ALUOp, Funct, flush,
    output ready, out_valid, alucontrol, jr, illegal, stall
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with multi-cycle MUL/DIV sequencing.
// Single-cycle ops complete one cycle after accept. MUL/DIV hold the block
// busy (stalling the pipeline) until their cycle count runs out. A flush
// abandons an in-flight op without producing a result.
module alu_control_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic                 clk,
  input logic                 reset,
  alu_control_seq_if.slave    bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_NOR  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(4'b1011);
  localparam logic [CTRL_W-1:0] C_MUL  = CTRL_W'(4'b1111);
  localparam logic [CTRL_W-1:0] C_DIV  = CTRL_W'(4'b1110);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              jr_q, jr_d;
  logic              illegal_q, illegal_d;
  logic              outValid_q, outValid_d;

  logic [CTRL_W-1:0] decCtrl;
  logic              decJr;
  logic              decIllegal;
  logic              decLong;
  logic [CNT_W-1:0]  decLoad;
  logic              accept;

  // Combinational decode of the current request into control code, flags and op length
  always_comb begin
    decCtrl    = C_ADD;
    decJr      = 1'b0;
    decIllegal = 1'b0;
    decLong    = 1'b0;
    decLoad    = '0;
    unique case (bus.ALUOp)
      3'd0: decCtrl = C_ADD;
      3'd1: decCtrl = C_SUB;
      3'd3: decCtrl = C_AND;
      3'd4: decCtrl = C_OR;
      3'd2: begin
        unique case (bus.Funct)
          6'd32: decCtrl = C_ADD;
          6'd34: decCtrl = C_SUB;
          6'd36: decCtrl = C_AND;
          6'd37: decCtrl = C_OR;
          6'd39: decCtrl = C_NOR;
          6'd42: decCtrl = C_SLT;
          6'd41: decCtrl = C_SLTU;
          6'd0:  decCtrl = C_SLL;
          6'd2:  decCtrl = C_SRL;
          6'd24: begin
            decCtrl = C_MUL;
            decLong = 1'b1;
            decLoad = MUL_LOAD;
          end
          6'd26: begin
            decCtrl = C_DIV;
            decLong = 1'b1;
            decLoad = DIV_LOAD;
          end
          6'd8: begin
            decCtrl = C_AND;
            decJr   = 1'b1;
          end
          default: decIllegal = 1'b1;
        endcase
      end
      default: decIllegal = 1'b1;
    endcase
  end

  assign accept = bus.in_valid & (state_q == IDLE) & ~bus.flush;

  // Next-state logic: flush beats accept, and the busy counter retires MUL/DIV
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    jr_d       = jr_q;
    illegal_d  = illegal_q;
    outValid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ctrl_d    = decCtrl;
          jr_d      = decJr;
          illegal_d = decIllegal;
          if (decLong) begin
            state_d = BUSY;
            cnt_d   = decLoad;
          end else begin
            outValid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          outValid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      jr_q       <= 1'b0;
      illegal_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      jr_q       <= jr_d;
      illegal_q  <= illegal_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.stall      = (state_q == BUSY);
  assign bus.out_valid  = outValid_q;
  assign bus.alucontrol = ctrl_q;
  assign bus.jr         = jr_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed testbench for alu_control_seq with MUL_CYCLES=4 and DIV_CYCLES=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_alu_control_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_control_seq_if #(.CTRL_W(4)) bus ();

  alu_control_seq #(
    .CTRL_W(4),
    .MUL_CYCLES(4),
    .DIV_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // op(3) funct(6) ctrl(4) jr(1) illegal(1)
  logic [14:0] decVec [0:13] = '{
    {3'd0, 6'd0,  4'b0010, 1'b0, 1'b0},
    {3'd1, 6'd0,  4'b0110, 1'b0, 1'b0},
    {3'd3, 6'd0,  4'b0000, 1'b0, 1'b0},
    {3'd4, 6'd0,  4'b0001, 1'b0, 1'b0},
    {3'd2, 6'd36, 4'b0000, 1'b0, 1'b0},
    {3'd2, 6'd37, 4'b0001, 1'b0, 1'b0},
    {3'd2, 6'd39, 4'b1100, 1'b0, 1'b0},
    {3'd2, 6'd41, 4'b0100, 1'b0, 1'b0},
    {3'd2, 6'd0,  4'b0011, 1'b0, 1'b0},
    {3'd2, 6'd2,  4'b1011, 1'b0, 1'b0},
    {3'd2, 6'd8,  4'b0000, 1'b1, 1'b0},
    {3'd7, 6'd0,  4'b0010, 1'b0, 1'b1},
    {3'd5, 6'd32, 4'b0010, 1'b0, 1'b1},
    {3'd2, 6'd63, 4'b0010, 1'b0, 1'b1}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic fl);
    bus.in_valid = v;
    bus.ALUOp    = op;
    bus.Funct    = fn;
    bus.flush    = fl;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.ready, bus.stall, bus.out_valid, bus.alucontrol, bus.jr, bus.illegal} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b stall=%b ov=%b ctrl=%b jr=%b ill=%b, expected 1 0 0 0000 0 0",
               bus.ready, bus.stall, bus.out_valid, bus.alucontrol, bus.jr, bus.illegal);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got ov=%b rdy=%b, expected 0 1", bus.out_valid, bus.ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn  [0:2] = '{6'd32, 6'd34, 6'd42};
    logic [3:0] exp [0:2] = '{4'b0010, 4'b0110, 4'b0111};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd2, fn[i], 1'b0);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.alucontrol !== exp[i]) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got ov=%b ctrl=%b, expected 1 %b", i, bus.out_valid, bus.alucontrol, exp[i]);
      end
    end
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got ov=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_mul();
    drive(1'b1, 3'd2, 6'd24, 1'b0);
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.stall !== 1'b1 || bus.ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.alucontrol !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL mul_busy_T+%0d: got stall=%b rdy=%b ov=%b ctrl=%b, expected 1 0 0 1111",
                 k, bus.stall, bus.ready, bus.out_valid, bus.alucontrol);
      end
      if (k == 2) drive(1'b1, 3'd0, 6'd0, 1'b0);
      else        drive(1'b0, 3'd0, 6'd0, 1'b0);
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.stall !== 1'b0 || bus.ready !== 1'b1 || bus.alucontrol !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL mul_done_T+4: got ov=%b stall=%b rdy=%b ctrl=%b, expected 1 0 1 1111",
               bus.out_valid, bus.stall, bus.ready, bus.alucontrol);
    end
    drive(1'b1, 3'd1, 6'd0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alucontrol !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL mul_followon_sub: got ov=%b ctrl=%b, expected 1 0110", bus.out_valid, bus.alucontrol);
    end
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_pulse_end: got ov=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_div_flush();
    int ovSeen;
    drive(1'b1, 3'd2, 6'd26, 1'b0);
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1 || bus.alucontrol !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL div_start: got stall=%b ctrl=%b, expected 1 1110", bus.stall, bus.alucontrol);
    end
    step();
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b1);
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0 || bus.ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alucontrol !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL div_flush_T+4: got stall=%b rdy=%b ov=%b ctrl=%b, expected 0 1 0 1110",
               bus.stall, bus.ready, bus.out_valid, bus.alucontrol);
    end
    ovSeen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.out_valid === 1'b1) ovSeen++;
    end
    checks++;
    if (ovSeen != 0) begin
      errors++;
      $display("[TB] FAIL div_flush_no_valid: got %0d out_valid pulses, expected 0", ovSeen);
    end
    drive(1'b1, 3'd0, 6'd0, 1'b1);
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_flush_block: got ov=%b rdy=%b, expected 0 1", bus.out_valid, bus.ready);
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, decVec[i][14:12], decVec[i][11:6], 1'b0);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.alucontrol !== decVec[i][5:2] ||
          bus.jr !== decVec[i][1] || bus.illegal !== decVec[i][0] || bus.stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL decode_op%0d_fn%0d: got ov=%b ctrl=%b jr=%b ill=%b stall=%b, expected 1 %b %b %b 0",
                 decVec[i][14:12], decVec[i][11:6], bus.out_valid, bus.alucontrol, bus.jr, bus.illegal,
                 bus.stall, decVec[i][5:2], decVec[i][1], decVec[i][0]);
      end
    end
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, 3'd2, 6'd26, 1'b0);
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.ready, bus.stall, bus.out_valid, bus.alucontrol, bus.jr, bus.illegal} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_div: got rdy=%b stall=%b ov=%b ctrl=%b jr=%b ill=%b, expected 1 0 0 0000 0 0",
               bus.ready, bus.stall, bus.out_valid, bus.alucontrol, bus.jr, bus.illegal);
    end
    drive(1'b1, 3'd0, 6'd0, 1'b0);
    step();
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alucontrol !== 4'b0010 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_after_reset: got ov=%b ctrl=%b ill=%b, expected 1 0010 0",
               bus.out_valid, bus.alucontrol, bus.illegal);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_after_reset_end: got ov=%b stall=%b, expected 0 0", bus.out_valid, bus.stall);
    end
  endtask

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 3'd0, 6'd0, 1'b0);
    test_reset();
    test_back_to_back();
    test_mul();
    test_div_flush();
    test_decode();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
